// File: rtl/myproject_div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package myproject_div_pkg;

  localparam int unsigned DIN0_WIDTH = 21;
  localparam int unsigned DIN1_WIDTH = 5;
  localparam int unsigned DOUT_WIDTH = 16;
  localparam int unsigned REM_WIDTH  = 6;

  // Counter wide enough to count din0_WIDTH-1 down to 0.
  localparam int unsigned CNT_W = $clog2(DIN0_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX
  } state_t;

endpackage

// File: rtl/myproject_sdiv_21s_5ns_16_seq_1_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface myproject_sdiv_21s_5ns_16_seq_1_if #(
  parameter int din0_WIDTH = 21,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 16,
  parameter int rem_WIDTH  = 6
) ();

  logic                  ce;
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  idle;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [rem_WIDTH-1:0]  rem;

  modport master (
    output ce, start, din0, din1,
    input  idle, done, dout, rem
  );

  modport slave (
    input  ce, start, din0, din1,
    output idle, done, dout, rem
  );

endinterface

// File: rtl/myproject_div_step.sv
// One radix-2 restoring division step on magnitudes.
module myproject_div_step #(
  parameter int DSR_W = 5
) (
  input  logic [DSR_W-1:0] prem_i,
  input  logic [DSR_W-1:0] dsr_i,
  input  logic             bit_i,
  output logic [DSR_W:0]   prem_o,
  output logic             qbit_o
);

  logic [DSR_W:0] shifted;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    shifted = {prem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, dsr_i});
    prem_o  = qbit_o ? (shifted - {1'b0, dsr_i}) : shifted;
  end

endmodule

// File: rtl/myproject_sdiv_21s_5ns_16_seq_1.sv
// Sequential signed-dividend / unsigned-divisor divider, one quotient bit per cycle.
module myproject_sdiv_21s_5ns_16_seq_1
  import myproject_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH,
  parameter int din1_WIDTH = DIN1_WIDTH,
  parameter int dout_WIDTH = DOUT_WIDTH,
  parameter int rem_WIDTH  = REM_WIDTH
) (
  input logic clk,
  input logic reset,
  myproject_sdiv_21s_5ns_16_seq_1_if.slave bus
);

  // Reject configurations the datapath cannot represent.
  if ((rem_WIDTH != din1_WIDTH + 1) || (din0_WIDTH > (1 << CNT_W)) || (ID < 0)) begin : g_bad_cfg
    $error("myproject_sdiv_21s_5ns_16_seq_1: invalid parameter set");
  end

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [din0_WIDTH-1:0] dvd_q,   dvd_d;
  logic [din1_WIDTH-1:0] dsr_q,   dsr_d;
  logic                  neg_q,   neg_d;
  logic [din1_WIDTH:0]   prem_q,  prem_d;
  logic [dout_WIDTH-1:0] dout_q,  dout_d;
  logic [rem_WIDTH-1:0]  rem_q,   rem_d;
  logic                  done_q,  done_d;

  logic [din1_WIDTH:0]   step_prem;
  logic                  step_qbit;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom.
  myproject_div_step #(
    .DSR_W (din1_WIDTH)
  ) u_step (
    .prem_i (prem_q[din1_WIDTH-1:0]),
    .dsr_i  (dsr_q),
    .bit_i  (dvd_q[din0_WIDTH-1]),
    .prem_o (step_prem),
    .qbit_o (step_qbit)
  );

  // State register, frozen while ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (bus.ce) begin
      state_q <= state_d;
    end
  end

  // Next state, operand capture, iteration and sign fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    neg_d   = neg_q;
    prem_d  = prem_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          neg_d   = bus.din0[din0_WIDTH-1];
          dvd_d   = bus.din0[din0_WIDTH-1] ? ('0 - bus.din0) : bus.din0;
          dsr_d   = bus.din1;
          prem_d  = '0;
          cnt_d   = CNT_W'(din0_WIDTH - 1);
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[din0_WIDTH-2:0], step_qbit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (dsr_q == '0) begin
          dout_d = '1;
          rem_d  = '0;
        end else begin
          dout_d = dout_WIDTH'(neg_q ? ('0 - dvd_q) : dvd_q);
          rem_d  = rem_WIDTH'(neg_q ? ('0 - prem_q) : prem_q);
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and result registers, frozen while ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      prem_q <= '0;
      dout_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else if (bus.ce) begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      neg_q  <= neg_d;
      prem_q <= prem_d;
      dout_q <= dout_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign bus.idle = (state_q == ST_IDLE);
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_myproject_sdiv_21s_5ns_16_seq_1.sv
// Directed bench for the sequential signed divider.
module tb_myproject_sdiv_21s_5ns_16_seq_1;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  myproject_sdiv_21s_5ns_16_seq_1_if #(
    .din0_WIDTH (21),
    .din1_WIDTH (5),
    .dout_WIDTH (16),
    .rem_WIDTH  (6)
  ) bus ();

  myproject_sdiv_21s_5ns_16_seq_1 #(
    .ID         (1),
    .din0_WIDTH (21),
    .din1_WIDTH (5),
    .dout_WIDTH (16),
    .rem_WIDTH  (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one division starting now (just after a rising edge) and waits for done.
  // lat counts rising edges from the accept edge (counted as 1) until done is seen.
  // With gap set, ce drops for 5 cycles mid-ITER and a start pulse is sent while busy.
  task automatic run_div(input string tag, input logic [20:0] a, input logic [4:0] b,
                         input bit gap, input int exp_lat,
                         input logic [15:0] exp_q, input logic [5:0] exp_r);
    int lat;
    bit gapped;
    bus.start = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat    = 1;
    gapped = 1'b0;
    while (!bus.done && lat < 80) begin
      if (gap && lat == 10 && !gapped) begin
        bus.ce = 1'b0;
        gapped = 1'b1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        bus.ce = 1'b1;
      end else begin
        if (gap && lat == 5) begin
          bus.start = 1'b1;
          bus.din0  = 21'd9;
          bus.din1  = 5'd3;
        end
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, " idle"}, {31'd0, bus.idle}, 32'd1);
    chk({tag, " dout"}, {16'd0, bus.dout}, {16'd0, exp_q});
    chk({tag, " rem"},  {26'd0, bus.rem},  {26'd0, exp_r});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset idle", {31'd0, bus.idle}, 32'd1);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset dout", {16'd0, bus.dout}, 32'd0);
    chk("reset rem",  {26'd0, bus.rem},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each start is issued in the cycle done is high.
    run_div("100/7",    21'd100,       5'd7,  1'b0, 23, 16'h000E, 6'h02);
    run_div("-100/7",   21'h1FFF9C,    5'd7,  1'b0, 23, 16'hFFF2, 6'h3E);
    run_div("min/31",   21'h100000,    5'd31, 1'b0, 23, 16'h7BDF, 6'h3F);
    run_div("50/0",     21'd50,        5'd0,  1'b0, 23, 16'hFFFF, 6'h00);
    run_div("max/1",    21'h0FFFFF,    5'd1,  1'b0, 23, 16'hFFFF, 6'h00);
    run_div("-7/31",    21'h1FFFF9,    5'd31, 1'b0, 23, 16'h0000, 6'h39);

    // A done held by ce=0 stays high, then drops on the next enabled cycle.
    bus.ce = 1'b0;
    @(posedge clk); #1;
    chk("ce hold done", {31'd0, bus.done}, 32'd1);
    bus.ce = 1'b1;
    @(posedge clk); #1;
    chk("done pulse end", {31'd0, bus.done}, 32'd0);
    chk("dout held",      {16'd0, bus.dout}, 32'h0000);
    chk("rem held",       {26'd0, bus.rem},  32'h39);

    run_div("100/7 gap", 21'd100, 5'd7, 1'b1, 28, 16'h000E, 6'h02);
    @(posedge clk); #1;
    chk("busy start ignored idle", {31'd0, bus.idle}, 32'd1);

    // Reset in the middle of ITER discards the operation.
    bus.start = 1'b1;
    bus.din0  = 21'd100;
    bus.din1  = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'd0, bus.idle}, 32'd0);
    reset = 1'b1;
    #1;
    chk("midop reset idle", {31'd0, bus.idle}, 32'd1);
    chk("midop reset done", {31'd0, bus.done}, 32'd0);
    chk("midop reset dout", {16'd0, bus.dout}, 32'd0);
    chk("midop reset rem",  {26'd0, bus.rem},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_div("9/3", 21'd9, 5'd3, 1'b0, 23, 16'h0003, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
